// File: rtl/feeder_pll_pkg.sv
// ---------------------------------------------------------------------------
// feeder_pll_pkg
//
// Shared definitions for the feeder PLL reset sequencer:
//   - state_t        : sequencer states
//   - CNT_W_DEFAULT  : default width of the shared timers
//   - sat_inc8       : saturating 8-bit increment used by the lock-loss counter
// ---------------------------------------------------------------------------
package feeder_pll_pkg;

    localparam int CNT_W_DEFAULT = 17;

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    // Increment that sticks at 255 instead of wrapping to 0.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//
// Two-flop single-bit synchroniser with asynchronous active-high reset to 0.
// Output follows the input with two clock cycles of latency.
//
// Ports:
//   i_clk  in   destination clock
//   i_rst  in   asynchronous active-high reset
//   i_d    in   asynchronous input bit
//   o_q    out  synchronised bit
// ---------------------------------------------------------------------------
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // First flop may go metastable; the second gives it a full cycle to settle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/feeder_pll_reset_ctrl.sv
// ---------------------------------------------------------------------------
// feeder_pll_reset_ctrl
//
// Sequences the feeder PLL in the refclk domain: pulses the PLL reset, waits
// for a debounced lock, then releases sys_rst to logic clocked by the PLL.
// Lock loss in RUN re-sequences; lock timeouts retry up to MAX_RETRIES times
// before parking in FAULT until software asks for a relock.
//
// Ports:
//   i_refclk         in   free-running reference clock (sole clock)
//   i_rst            in   asynchronous active-high reset
//   i_pll_locked     in   PLL lock, asynchronous to refclk
//   i_sw_relock      in   one-cycle request to restart the sequence / clear fault
//   o_pll_rst        out  active-high reset to the PLL
//   o_sys_rst        out  active-high reset for downstream logic
//   o_ready          out  high only in RUN
//   o_fault          out  high only in FAULT
//   o_retry_cnt      out  lock timeouts in the current attempt series
//   o_lock_loss_cnt  out  lock losses seen in RUN, saturating at 255
// ---------------------------------------------------------------------------
module feeder_pll_reset_ctrl
    import feeder_pll_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 3,
    parameter int CNT_W               = CNT_W_DEFAULT
) (
    input  logic       i_refclk,
    input  logic       i_rst,
    input  logic       i_pll_locked,
    input  logic       i_sw_relock,
    output logic       o_pll_rst,
    output logic       o_sys_rst,
    output logic       o_ready,
    output logic       o_fault,
    output logic [1:0] o_retry_cnt,
    output logic [7:0] o_lock_loss_cnt
);

    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
    // The WAIT_LOCK cycle that first sees lock already counts as stable cycle 1,
    // so STABILIZE needs LOCK_STABLE_CYCLES-1 further good cycles.
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 2);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRIES);

    logic             w_lock_s;

    state_t           r_state;
    logic [CNT_W-1:0] r_pulse_t;
    logic [CNT_W-1:0] r_stable_t;
    logic [CNT_W-1:0] r_timeout_t;
    logic [1:0]       r_retry_cnt;
    logic [7:0]       r_lock_loss_cnt;
    logic             r_pll_rst;
    logic             r_sys_rst;
    logic             r_ready;
    logic             r_fault;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_pulse_nxt;
    logic [CNT_W-1:0] w_stable_nxt;
    logic [CNT_W-1:0] w_timeout_nxt;
    logic [1:0]       w_retry_nxt;
    logic [7:0]       w_loss_nxt;

    sync_2ff u_lock_sync (
        .i_clk (i_refclk),
        .i_rst (i_rst),
        .i_d   (i_pll_locked),
        .o_q   (w_lock_s)
    );

    // Next-state and counter logic. Timers default to zero so that each one is
    // automatically cleared whenever the FSM is outside the states that use it;
    // the timeout timer therefore survives STABILIZE<->WAIT_LOCK bounces.
    always_comb begin
        w_state_nxt   = r_state;
        w_pulse_nxt   = '0;
        w_stable_nxt  = '0;
        w_timeout_nxt = '0;
        w_retry_nxt   = r_retry_cnt;
        w_loss_nxt    = r_lock_loss_cnt;

        case (r_state)
            ST_RESET_PLL: begin
                if (r_pulse_t == PULSE_LAST) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end else begin
                    w_pulse_nxt = r_pulse_t + 1'b1;
                end
            end

            ST_WAIT_LOCK, ST_STABILIZE: begin
                w_timeout_nxt = r_timeout_t + 1'b1;
                if (r_timeout_t == TIMEOUT_LAST) begin
                    if (r_retry_cnt == RETRY_MAX) begin
                        w_state_nxt = ST_FAULT;
                    end else begin
                        w_retry_nxt = r_retry_cnt + 2'd1;
                        w_state_nxt = ST_RESET_PLL;
                    end
                end else if (i_sw_relock) begin
                    w_retry_nxt = '0;
                    w_state_nxt = ST_RESET_PLL;
                end else if (r_state == ST_WAIT_LOCK) begin
                    if (w_lock_s) begin
                        w_state_nxt = ST_STABILIZE;
                    end
                end else if (!w_lock_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end else if (r_stable_t == STABLE_LAST) begin
                    w_retry_nxt = '0;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_stable_nxt = r_stable_t + 1'b1;
                end
            end

            ST_RUN: begin
                // Lock loss takes precedence so a coincident relock is still counted.
                if (!w_lock_s) begin
                    w_loss_nxt  = sat_inc8(r_lock_loss_cnt);
                    w_state_nxt = ST_RESET_PLL;
                end else if (i_sw_relock) begin
                    w_state_nxt = ST_RESET_PLL;
                end
            end

            ST_FAULT: begin
                if (i_sw_relock) begin
                    w_retry_nxt = '0;
                    w_state_nxt = ST_RESET_PLL;
                end
            end

            default: begin
                w_state_nxt = ST_RESET_PLL;
            end
        endcase
    end

    // All state, counters and outputs are registered together; outputs are
    // decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge i_refclk or posedge i_rst) begin
        if (i_rst) begin
            r_state         <= ST_RESET_PLL;
            r_pulse_t       <= '0;
            r_stable_t      <= '0;
            r_timeout_t     <= '0;
            r_retry_cnt     <= '0;
            r_lock_loss_cnt <= '0;
            r_pll_rst       <= 1'b1;
            r_sys_rst       <= 1'b1;
            r_ready         <= 1'b0;
            r_fault         <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_pulse_t       <= w_pulse_nxt;
            r_stable_t      <= w_stable_nxt;
            r_timeout_t     <= w_timeout_nxt;
            r_retry_cnt     <= w_retry_nxt;
            r_lock_loss_cnt <= w_loss_nxt;
            r_pll_rst       <= (w_state_nxt == ST_RESET_PLL) || (w_state_nxt == ST_FAULT);
            r_sys_rst       <= (w_state_nxt != ST_RUN);
            r_ready         <= (w_state_nxt == ST_RUN);
            r_fault         <= (w_state_nxt == ST_FAULT);
        end
    end

    assign o_pll_rst       = r_pll_rst;
    assign o_sys_rst       = r_sys_rst;
    assign o_ready         = r_ready;
    assign o_fault         = r_fault;
    assign o_retry_cnt     = r_retry_cnt;
    assign o_lock_loss_cnt = r_lock_loss_cnt;

endmodule
